// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - logic-analyser capture controller; LA_TRIG_TIMEOUT_EN adds a forced-trigger timeout
// Synchronises probes, divides the sample tick, waits for a masked level/edge trigger and streams samples to the buffer.

module la_capture_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 49152,
    parameter int DIV_W  = 16,
    parameter int TMO_W  = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] probe,
    input  logic              arm,
    input  logic              abort,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] trig_edge,
    input  logic [15:0]       capture_len,
    input  logic              buf_full,
`ifdef LA_TRIG_TIMEOUT_EN
    input  logic [TMO_W-1:0]  tmo_limit,
    output logic              timed_out,
`endif
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic              buf_clear,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [15:0]       captured
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_sync1;
    logic [DATA_W-1:0] r_sync2;
    logic [DATA_W-1:0] r_cur;
    logic              r_cur_vld;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic              r_triggered;
    logic              r_done;
    logic [15:0]       r_captured;

    logic              w_run;
    logic              w_tick;
    logic              w_hit;
    logic              w_fire;
    logic              w_tmo_hit;
    logic              w_arm_ok;
    logic [DATA_W-1:0] w_lvl_ok;
    logic [DATA_W-1:0] w_edge_ok;
    logic [DATA_W-1:0] w_bit_ok;
    logic [15:0]       w_eff_len;
    logic [15:0]       w_cap_next;

    assign w_run  = (r_state == S_WAIT) || (r_state == S_CAPT);
    assign w_tick = w_run && (r_div_cnt == div);

    // Trigger is evaluated on the sample being taken this tick (r_sync2) against the previous one (r_cur).
    assign w_lvl_ok  = ~(r_sync2 ^ trig_value);
    assign w_edge_ok = w_lvl_ok & (r_cur ^ r_sync2) & {DATA_W{r_cur_vld}};
    assign w_bit_ok  = (trig_edge & w_edge_ok) | (~trig_edge & w_lvl_ok);
    assign w_hit     = &(w_bit_ok | ~trig_mask);
    assign w_fire    = w_hit || w_tmo_hit;

    assign w_eff_len  = (capture_len == 16'd0 || {1'b0, capture_len} > DEPTH_L) ? DEPTH_L[15:0] : capture_len;
    assign w_cap_next = r_captured + 16'd1;
    assign w_arm_ok   = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef LA_TRIG_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timed_out;

    assign w_tmo_hit = (r_state == S_WAIT) && w_tick && (tmo_limit != '0)
                       && (r_tmo_cnt + TMO_W'(1) == tmo_limit);
    assign timed_out = r_timed_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt   <= '0;
            r_timed_out <= 1'b0;
        end else if (w_arm_ok) begin
            r_tmo_cnt   <= '0;
            r_timed_out <= 1'b0;
        end else if (!abort && (r_state == S_WAIT) && w_tick) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_tmo_hit && !w_hit) begin
                r_timed_out <= 1'b1;
            end
        end
    end
`else
    // A zero-width timeout counter is impossible, so this is constant low.
    assign w_tmo_hit = (TMO_W < 1);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cur       <= '0;
            r_cur_vld   <= 1'b0;
            r_div_cnt   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_captured  <= '0;
        end else begin
            r_sync1 <= probe;
            r_sync2 <= r_sync1;
            r_wr_en <= 1'b0;

            if (w_run && !w_tick && !abort) begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end else begin
                r_div_cnt <= '0;
            end

            if (w_tick) begin
                r_cur     <= r_sync2;
                r_cur_vld <= 1'b1;
            end

            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            r_state     <= S_CLEAR;
                            r_done      <= 1'b0;
                            r_triggered <= 1'b0;
                            r_captured  <= '0;
                            r_cur_vld   <= 1'b0;
                        end
                    end
                    S_CLEAR: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_tick && w_fire) begin
                            r_triggered <= 1'b1;
                            r_wr_en     <= 1'b1;
                            r_wr_data   <= r_sync2;
                            r_captured  <= 16'd1;
                            if (w_eff_len == 16'd1) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_CAPT;
                            end
                        end
                    end
                    S_CAPT: begin
                        if (buf_full) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_tick) begin
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= r_sync2;
                            r_captured <= w_cap_next;
                            if (w_cap_next == w_eff_len) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;
    assign buf_clear = (r_state == S_CLEAR);
    assign busy      = (r_state == S_CLEAR) || w_run;
    assign triggered = r_triggered;
    assign done      = r_done;
    assign captured  = r_captured;

endmodule
